// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the UART TX scheduler slice.
//   arb_state_t        : requester arbiter states
//   drain_state_t      : FIFO-to-transmitter drain states
//   UART_TX_FIFO_DEPTH : default TX FIFO depth
// No ports.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int UART_TX_FIFO_DEPTH = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_PRESENT,
        D_HOLD
    } drain_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_if
// Bundles the requester and transmitter-side signals of uart_tx_sched.
//   req_valid/req_data/req_last/req_ready : NREQ byte-stream requesters
//   tx_pop/tx_sreg_empty                  : from the TX shifter
//   tx_din/tx_thre/temt                   : to the TX shifter / LSR
//   fifo_level/grant_id                   : status
//   fifo_flush                            : only when UART_TX_SCHED_FLUSH_EN defined
// Modports: master = sources/transmitter side, slave = scheduler.
// -----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int NREQ  = 4,
    parameter int LVL_W = 5
);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_pop;
    logic              tx_sreg_empty;
    logic [7:0]        tx_din;
    logic              tx_thre;
    logic [LVL_W-1:0]  fifo_level;
    logic [2:0]        grant_id;
    logic              temt;
`ifdef UART_TX_SCHED_FLUSH_EN
    logic              fifo_flush;

    modport master (
        output req_valid, req_data, req_last, tx_pop, tx_sreg_empty, fifo_flush,
        input  req_ready, tx_din, tx_thre, fifo_level, grant_id, temt
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_pop, tx_sreg_empty, fifo_flush,
        output req_ready, tx_din, tx_thre, fifo_level, grant_id, temt
    );
`else
    modport master (
        output req_valid, req_data, req_last, tx_pop, tx_sreg_empty,
        input  req_ready, tx_din, tx_thre, fifo_level, grant_id, temt
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_pop, tx_sreg_empty,
        output req_ready, tx_din, tx_thre, fifo_level, grant_id, temt
    );
`endif

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with occupancy count. Head is read combinationally.
// Ports:
//   clk, rst (async, active-high)
//   i_push, i_din   : write one byte (caller guarantees not full)
//   i_retire        : drop the head byte (caller guarantees not empty)
//   i_flush         : empty the FIFO; wins over push/retire
//   o_head          : byte at the read pointer
//   o_level         : occupancy 0..DEPTH
//   o_full, o_empty : occupancy flags
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [7:0]       i_din,
    input  logic             i_retire,
    input  logic             i_flush,
    output logic [7:0]       o_head,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_retire;

    assign w_push   = i_push & ~i_flush;
    assign w_retire = i_retire & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_retire})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Multi-requester front end for the 16550-style UART transmitter. Round-robin
// arbitrates NREQ byte streams into a shared TX FIFO with packet atomicity and
// presents the FIFO head as tx_din/tx_thre, retiring a byte per tx_pop pulse.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : uart_tx_sched_if.slave (requester handshake, transmitter side,
//          fifo_level, grant_id, temt)
// Build option: define UART_TX_SCHED_FLUSH_EN to add bus.fifo_flush, a
// one-cycle pulse that empties the FIFO and aborts the current packet.
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_sched_if.slave   bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       r_arb, w_arb_next;
    drain_state_t     r_drain, w_drain_next;
    logic [IDX_W-1:0] r_owner, w_owner_next;
    logic [IDX_W-1:0] r_last_grant, w_last_next;
    logic [IDX_W-1:0] w_pick, w_idx;
    logic             w_found;
    logic [NREQ-1:0]  w_ready;
    logic             w_push;
    logic             w_retire;
    logic             w_flush;
    logic             w_hold_idle;
    logic             r_pop_q;
    logic             w_pop_rise;
    logic             w_pop_fall;
    logic [7:0]       w_head;
    logic [7:0]       w_push_data;
    logic [LVL_W-1:0] w_level;
    logic             w_full;
    logic             w_empty;

`ifdef UART_TX_SCHED_FLUSH_EN
    logic r_flush_hold;

    assign w_flush = bus.fifo_flush;

    // After a flush the transmitter may still be mid-pop; keep the drain idle
    // until that pop level drops so a stale falling edge cannot retire a byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_hold <= 1'b0;
        end else if (w_flush) begin
            r_flush_hold <= 1'b1;
        end else if (!bus.tx_pop) begin
            r_flush_hold <= 1'b0;
        end
    end

    assign w_hold_idle = r_flush_hold;
`else
    assign w_flush     = 1'b0;
    assign w_hold_idle = 1'b0;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_din    (w_push_data),
        .i_retire (w_retire),
        .i_flush  (w_flush),
        .o_head   (w_head),
        .o_level  (w_level),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_push_data = bus.req_data[{r_owner, 3'b000} +: 8];

    // ---------------- arbiter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arb        <= ARB_IDLE;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(NREQ - 1);
        end else begin
            r_arb        <= w_arb_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_next;
        end
    end

    always_comb begin
        w_arb_next   = r_arb;
        w_owner_next = r_owner;
        w_last_next  = r_last_grant;
        w_ready      = '0;
        w_push       = 1'b0;
        w_found      = 1'b0;
        w_pick       = '0;
        w_idx        = '0;

        // Rotating priority: first valid requester after the last grant.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDX_W'((32'(r_last_grant) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end

        case (r_arb)
            ARB_IDLE: begin
                if (w_found) begin
                    w_owner_next = w_pick;
                    w_arb_next   = ARB_OWN;
                end
            end
            ARB_OWN: begin
                w_ready[r_owner] = ~w_full & ~w_flush;
                w_push           = bus.req_valid[r_owner] & ~w_full & ~w_flush;
                if (w_push && bus.req_last[r_owner]) begin
                    w_last_next = r_owner;
                    w_arb_next  = ARB_IDLE;
                end
            end
            default: w_arb_next = ARB_IDLE;
        endcase

        if (w_flush) begin
            w_arb_next = ARB_IDLE;
            if (r_arb == ARB_OWN) begin
                w_last_next = r_owner;
            end
        end
    end

    // ---------------- drain ----------------
    assign w_pop_rise = bus.tx_pop & ~r_pop_q;
    assign w_pop_fall = ~bus.tx_pop & r_pop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain <= D_IDLE;
            r_pop_q <= 1'b0;
        end else begin
            r_drain <= w_drain_next;
            r_pop_q <= bus.tx_pop;
        end
    end

    always_comb begin
        w_drain_next = r_drain;
        w_retire     = 1'b0;
        case (r_drain)
            D_IDLE: begin
                if (!w_empty && !w_hold_idle) begin
                    w_drain_next = D_PRESENT;
                end
            end
            D_PRESENT: begin
                if (w_pop_rise) begin
                    w_drain_next = D_HOLD;
                end
            end
            D_HOLD: begin
                if (w_pop_fall) begin
                    w_retire = 1'b1;
                    // Still non-empty after this retire unless it held the
                    // last byte and nothing is being pushed alongside it.
                    if (w_level != LVL_W'(1) || w_push) begin
                        w_drain_next = D_PRESENT;
                    end else begin
                        w_drain_next = D_IDLE;
                    end
                end
            end
            default: w_drain_next = D_IDLE;
        endcase

        if (w_flush) begin
            w_drain_next = D_IDLE;
            w_retire     = 1'b0;
        end
    end

    // ---------------- outputs ----------------
    // thre comes straight off the registered level, so it moves on the same
    // edge that commits a push or retire. Head is frozen in D_HOLD because the
    // read pointer only moves on the retiring edge.
    assign bus.req_ready  = w_ready;
    assign bus.tx_thre    = w_empty;
    assign bus.tx_din     = w_empty ? 8'h00 : w_head;
    assign bus.fifo_level = w_level;
    assign bus.grant_id   = 3'(r_owner);
    assign bus.temt       = w_empty & bus.tx_sreg_empty;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed bench for uart_tx_sched: requester beats are planned per requester
// with their expected FIFO order queued at planning time; each drained byte is
// popped from that queue and compared. Honours UART_TX_SCHED_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NREQ(NREQ), .LVL_W(LVL_W)) bus ();

    uart_tx_sched #(
        .NREQ       (NREQ),
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] pend_d [NREQ][$];
    logic       pend_l [NREQ][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue one beat for requester r; expected FIFO order follows call order.
    task automatic plan(input int r, input logic [7:0] d, input logic l);
        pend_d[r].push_back(d);
        pend_l[r].push_back(l);
        exp_q.push_back(d);
    endtask

    function automatic int pending_total();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += pend_d[i].size();
        return s;
    endfunction

    task automatic run_drivers(input int budget, input bit must_finish);
        int n = 0;
        logic [NREQ-1:0] rdy;
        while (pending_total() != 0 && n < budget) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = (pend_d[i].size() != 0);
                if (pend_d[i].size() != 0) begin
                    bus.req_data[8*i +: 8] = pend_d[i][0];
                    bus.req_last[i]        = pend_l[i][0];
                end
            end
            @(negedge clk);
            rdy = bus.req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && rdy[i]) begin
                    chk("grant_owner", 32'(bus.grant_id), i);
                    void'(pend_d[i].pop_front());
                    void'(pend_l[i].pop_front());
                end
            end
            tick();
            n++;
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        if (must_finish) chk("drive_done", pending_total(), 0);
    endtask

    task automatic pop_start(output logic [7:0] e);
        int n = 0;
        while (bus.tx_thre !== 1'b0 && n < 32) begin
            tick();
            n++;
        end
        chk("thre_low", 32'(bus.tx_thre), 0);
        tick();
        bus.tx_pop = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk("din_head", 32'(bus.tx_din), 32'(e));
        tick();
    endtask

    task automatic pop_hold(input logic [7:0] e, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            chk("din_stable", 32'(bus.tx_din), 32'(e));
        end
    endtask

    task automatic pop_end();
        bus.tx_pop = 1'b0;
        tick();
    endtask

    task automatic drain_one(input int hold);
        logic [7:0] e;
        pop_start(e);
        pop_hold(e, hold);
        pop_end();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_din"},   32'(bus.tx_din), 0);
        chk({tag, "_thre"},  32'(bus.tx_thre), 1);
        chk({tag, "_level"}, 32'(bus.fifo_level), 0);
        chk({tag, "_grant"}, 32'(bus.grant_id), 0);
        chk({tag, "_temt"},  32'(bus.temt), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;

        rst               = 1'b1;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_last      = '0;
        bus.tx_pop        = 1'b0;
        bus.tx_sreg_empty = 1'b1;
`ifdef UART_TX_SCHED_FLUSH_EN
        bus.fifo_flush    = 1'b0;
`endif
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: single byte from req0
        chk("t1_thre_before", 32'(bus.tx_thre), 1);
        plan(0, 8'h13, 1'b1);
        run_drivers(10, 1'b1);
        chk("t1_level_push", 32'(bus.fifo_level), 1);
        chk("t1_thre_push", 32'(bus.tx_thre), 0);
        chk("t1_temt_push", 32'(bus.temt), 0);
        drain_one(4);
        chk("t1_level_done", 32'(bus.fifo_level), 0);
        chk("t1_thre_done", 32'(bus.tx_thre), 1);
        chk("t1_temt_done", 32'(bus.temt), 1);
        bus.tx_sreg_empty = 1'b0;
        #1;
        chk("t1_temt_sreg_busy", 32'(bus.temt), 0);
        bus.tx_sreg_empty = 1'b1;

        // 2: req0 and req2 contend from a fresh reset (last_grant = 3)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        plan(0, 8'hA1, 1'b1);
        plan(2, 8'hB1, 1'b0);
        plan(2, 8'hB2, 1'b0);
        plan(2, 8'hB3, 1'b1);
        plan(0, 8'hA2, 1'b1);
        run_drivers(30, 1'b1);
        chk("t2_level", 32'(bus.fifo_level), 5);
        for (int k = 0; k < 5; k++) drain_one(2);
        chk("t2_level_done", 32'(bus.fifo_level), 0);

        // 3: overfill with no pop
        for (int k = 0; k < 18; k++) plan(1, 8'(8'h40 + k), (k == 17));
        run_drivers(25, 1'b0);
        chk("t3_level_full", 32'(bus.fifo_level), 16);
        chk("t3_ready_full", 32'(bus.req_ready), 0);
        chk("t3_stalled", pending_total(), 2);
        drain_one(1);
        run_drivers(5, 1'b0);
        chk("t3_stalled_one", pending_total(), 1);
        chk("t3_level_refill", 32'(bus.fifo_level), 16);
        drain_one(1);
        run_drivers(5, 1'b1);
        chk("t3_level_refill2", 32'(bus.fifo_level), 16);
        for (int k = 0; k < 16; k++) drain_one(1);
        chk("t3_level_done", 32'(bus.fifo_level), 0);

        // 4: push coincident with pop falling edge at level 5
        for (int k = 0; k < 5; k++) plan(3, 8'(8'h60 + k), 1'b0);
        run_drivers(10, 1'b1);
        chk("t4_level", 32'(bus.fifo_level), 5);
        pop_start(e);
        pop_hold(e, 2);
        bus.tx_pop           = 1'b0;
        bus.req_valid[3]     = 1'b1;
        bus.req_data[24 +: 8] = 8'h65;
        bus.req_last[3]      = 1'b1;
        exp_q.push_back(8'h65);
        #1;
        chk("t4_ready_coincident", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        chk("t4_level_same", 32'(bus.fifo_level), 5);
        for (int k = 0; k < 5; k++) drain_one(1);
        chk("t4_level_done", 32'(bus.fifo_level), 0);

        // 5: long pop holds din and retires once
        plan(0, 8'hA5, 1'b0);
        plan(0, 8'h5A, 1'b1);
        run_drivers(10, 1'b1);
        chk("t5_level", 32'(bus.fifo_level), 2);
        pop_start(e);
        pop_hold(e, 160);
        chk("t5_level_in_hold", 32'(bus.fifo_level), 2);
        pop_end();
        chk("t5_level_one_retire", 32'(bus.fifo_level), 1);
        drain_one(2);
        chk("t5_level_done", 32'(bus.fifo_level), 0);

        // 6: reset mid-packet at level 7
        for (int k = 0; k < 7; k++) plan(2, 8'(8'h70 + k), 1'b0);
        run_drivers(12, 1'b1);
        chk("t6_level", 32'(bus.fifo_level), 7);
        chk("t6_grant", 32'(bus.grant_id), 2);
        bus.req_valid[2]      = 1'b1;
        bus.req_data[16 +: 8] = 8'h77;
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6_midreset");
        exp_q.delete();
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

`ifdef UART_TX_SCHED_FLUSH_EN
        // flush mid-packet: FIFO empties, owner released
        for (int k = 0; k < 3; k++) plan(1, 8'(8'h80 + k), 1'b0);
        run_drivers(10, 1'b1);
        chk("fl_level", 32'(bus.fifo_level), 3);
        exp_q.delete();
        bus.req_valid[1]      = 1'b1;
        bus.req_data[8 +: 8]  = 8'h83;
        bus.fifo_flush        = 1'b1;
        tick();
        bus.fifo_flush = 1'b0;
        chk("fl_level_zero", 32'(bus.fifo_level), 0);
        chk("fl_thre", 32'(bus.tx_thre), 1);
        chk("fl_ready", 32'(bus.req_ready), 0);
        bus.req_valid[2] = 1'b1;
        tick();
        chk("fl_next_owner", 32'(bus.grant_id), 2);
        bus.req_valid = '0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
